data_mem_responder: RTL and testbench

- Memory-side responder for the single-cycle MIPS core. Consumes the core's data-memory request (MemWrite, ALUOut as address, WriteData) and returns ReadData in the same cycle.
- Contains a word-addressed data RAM plus a small MMIO window:
  - a transmit FIFO drained through a valid/ready output port;
  - status, cycle-counter and error-counter registers.
- Sits beside the core in the top-level system, replacing a bare RAM.

---
 rtl/data_mem_responder_pkg.sv | 18 +
 rtl/data_mem_responder_tx_fifo.sv | 57 +++++
 rtl/data_mem_responder.sv | 126 ++++++++++++
 tb/tb_data_mem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// STATUS bit positions and the default MMIO window base.
package data_mem_responder_pkg;

  typedef logic [1:0] mmio_off_t;

  localparam mmio_off_t OFF_TX_DATA = 2'd0;
  localparam mmio_off_t OFF_STATUS  = 2'd1;
  localparam mmio_off_t OFF_CYCLE   = 2'd2;
  localparam mmio_off_t OFF_ERRCNT  = 2'd3;

  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVERFLOW = 2;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// Transmit FIFO: FIFO_DEPTH words of storage, head word always presented,
// a push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic [31:0] head_data,
  output logic        push_accepted
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_pop_s;

  assign empty         = (count_r == CW'(0));
  assign full          = (count_r == CW'(FIFO_DEPTH));
  assign do_pop_s      = pop && !empty;
  assign push_accepted = push && (!full || do_pop_s);
  assign head_data     = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 32'h0;
      end
    end else begin
      if (push_accepted) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_accepted, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus an MMIO
// window (TX FIFO push, STATUS, CYCLE and ERRCNT) with zero-latency reads.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]   ram_r [DEPTH_WORDS];
  logic [31:0]   cycle_r;
  logic [31:0]   errcnt_r;
  logic          overflow_r;

  logic          misaligned_s;
  logic          ram_hit_s;
  logic          mmio_hit_s;
  mmio_off_t     mmio_off_s;
  logic [AW-1:0] ram_idx_s;
  logic          push_req_s;
  logic          push_accepted_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [31:0]   status_s;

  // Address decode shared by reads and writes
  always_comb begin
    misaligned_s = (Addr[1:0] != 2'b00);
    ram_hit_s    = !misaligned_s && (Addr < RAM_BYTES);
    mmio_hit_s   = !misaligned_s && (Addr[31:4] == MMIO_BASE[31:4]);
    mmio_off_s   = Addr[3:2];
    ram_idx_s    = Addr[AW+1:2];
  end

  assign push_req_s = MemWrite && mmio_hit_s && (mmio_off_s == OFF_TX_DATA);
  assign pop_s      = tx_valid && tx_ready;
  assign tx_valid   = !empty_s;

  tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push_req_s),
    .push_data    (WriteData),
    .pop          (pop_s),
    .full         (full_s),
    .empty        (empty_s),
    .head_data    (tx_data),
    .push_accepted(push_accepted_s)
  );

  // Word RAM; contents survive reset, but reset still blocks the write
  always_ff @(posedge clk) begin
    if (!reset && MemWrite && ram_hit_s) begin
      ram_r[ram_idx_s] <= WriteData;
    end
  end

  // Cycle counter, saturating error counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_r    <= 32'h0;
      errcnt_r   <= 32'h0;
      overflow_r <= 1'b0;
    end else begin
      if (MemWrite && mmio_hit_s && (mmio_off_s == OFF_CYCLE)) begin
        cycle_r <= 32'h0;
      end else begin
        cycle_r <= cycle_r + 32'd1;
      end
      if (MemWrite && mmio_hit_s && (mmio_off_s == OFF_ERRCNT)) begin
        errcnt_r <= 32'h0;
      end else if (MemWrite && !ram_hit_s && !mmio_hit_s && (errcnt_r != 32'hFFFF_FFFF)) begin
        errcnt_r <= errcnt_r + 32'd1;
      end
      if (MemWrite && mmio_hit_s && (mmio_off_s == OFF_STATUS)) begin
        overflow_r <= 1'b0;
      end else if (push_req_s && !push_accepted_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // STATUS word assembly
  always_comb begin
    status_s              = 32'h0;
    status_s[ST_EMPTY]    = empty_s;
    status_s[ST_FULL]     = full_s;
    status_s[ST_OVERFLOW] = overflow_r;
  end

  // Zero-latency read mux; misaligned and unmapped addresses read 0
  always_comb begin
    ReadData = 32'h0;
    if (ram_hit_s) begin
      ReadData = ram_r[ram_idx_s];
    end else if (mmio_hit_s) begin
      case (mmio_off_s)
        OFF_TX_DATA: ReadData = 32'h0;
        OFF_STATUS:  ReadData = status_s;
        OFF_CYCLE:   ReadData = cycle_r;
        OFF_ERRCNT:  ReadData = errcnt_r;
        default:     ReadData = 32'h0;
      endcase
    end else begin
      ReadData = 32'h0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: a queue/array model of the responder is stepped at each
// rising edge and compared against the DUT at every falling edge.
module tb_data_mem_responder;

  localparam logic [31:0] MB = 32'hFFFF_FF00;
  localparam int          DW = 64;
  localparam int          FD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Addr = MB + 32'd4;
  logic [31:0] WriteData = 32'h0;
  logic        tx_ready = 1'b0;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [31:0] tx_data;

  int total = 0;
  int bad = 0;

  logic [31:0] m_ram [DW];
  bit          m_ramv [DW];
  logic [31:0] m_q [$];
  bit          m_ovf;
  logic [31:0] m_cyc;
  logic [31:0] m_err;
  bit          model_ok = 1'b0;

  data_mem_responder dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected read value from the model; returns 0 when the RAM word was never written
  function automatic bit exp_read(input logic [31:0] a, output logic [31:0] v);
    v = 32'h0;
    if (a[1:0] != 2'b00) return 1'b1;
    if (a < 32'(DW * 4)) begin
      v = m_ram[a[7:2]];
      return m_ramv[a[7:2]];
    end
    if (a[31:4] == MB[31:4]) begin
      case (a[3:2])
        2'd1:    v = {29'h0, m_ovf, (m_q.size() == FD), (m_q.size() == 0)};
        2'd2:    v = m_cyc;
        2'd3:    v = m_err;
        default: v = 32'h0;
      endcase
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    bit do_pop, push, clr_cyc;
    logic [31:0] a;
    a = Addr;
    if (reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 32'h0;
      m_err = 32'h0;
      model_ok = 1'b1;
    end else begin
      do_pop = (m_q.size() != 0) && tx_ready;
      push = 1'b0;
      clr_cyc = 1'b0;
      if (MemWrite) begin
        if (a[1:0] == 2'b00 && a < 32'(DW * 4)) begin
          m_ram[a[7:2]] = WriteData;
          m_ramv[a[7:2]] = 1'b1;
        end else if (a[1:0] == 2'b00 && a[31:4] == MB[31:4]) begin
          case (a[3:2])
            2'd0:    push = 1'b1;
            2'd1:    m_ovf = 1'b0;
            2'd2:    clr_cyc = 1'b1;
            default: m_err = 32'h0;
          endcase
        end else if (m_err != 32'hFFFF_FFFF) begin
          m_err = m_err + 32'd1;
        end
      end
      if (do_pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < FD) m_q.push_back(WriteData);
        else m_ovf = 1'b1;
      end
      m_cyc = clr_cyc ? 32'h0 : m_cyc + 32'd1;
    end
  endtask

  // One cycle: model sees the edge with the held inputs, then new inputs are applied
  task automatic drive(input logic rst, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy);
    @(posedge clk);
    model_step();
    #1;
    reset = rst;
    MemWrite = we;
    Addr = a;
    WriteData = wd;
    tx_ready = rdy;
    #1;
  endtask

  initial begin : compare
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        if (exp_read(Addr, e)) chk("read_data", ReadData, e);
        chk("tx_valid", {31'h0, tx_valid}, {31'h0, (m_q.size() != 0)});
        if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
      end
    end
  end

  initial begin : stim
    logic [31:0] a;
    logic [31:0] drain [4];
    drain = '{32'd11, 32'd12, 32'd13, 32'd9};

    drive(1'b1, 1'b0, MB + 32'd4, 32'h0, 1'b0);
    drive(1'b1, 1'b0, MB + 32'd4, 32'h0, 1'b0);
    chk("reset_status", ReadData, 32'h1);
    chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("reset_tx_data", tx_data, 32'h0);
    reset = 1'b0;

    // cycle counter from reset, then clear
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, MB + 32'd8, 32'h0, 1'b0);
    chk("cycle_10", ReadData, 32'd10);
    drive(1'b0, 1'b1, MB + 32'd8, 32'h1234, 1'b0);
    chk("cycle_11", ReadData, 32'd11);
    drive(1'b0, 1'b0, MB + 32'd8, 32'h0, 1'b0);
    chk("cycle_cleared", ReadData, 32'd0);
    drive(1'b0, 1'b0, MB + 32'd8, 32'h0, 1'b0);
    chk("cycle_after_clear", ReadData, 32'd1);

    // RAM write / read-during-write
    drive(1'b0, 1'b1, 32'h10, 32'h1111_1111, 1'b0);
    drive(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    chk("ram_rdw_old", ReadData, 32'h1111_1111);
    drive(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("ram_read_new", ReadData, 32'hDEAD_BEEF);

    // fill, overflow, drain
    for (int k = 1; k <= 4; k++) drive(1'b0, 1'b1, MB, 32'(k), 1'b0);
    drive(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b0);
    chk("status_full", ReadData, 32'h2);
    drive(1'b0, 1'b1, MB, 32'd5, 1'b0);
    chk("tx_data_reg_reads_0", ReadData, 32'h0);
    drive(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b0);
    chk("status_full_ovf", ReadData, 32'h6);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b1);
      chk("drain_data", tx_data, 32'(k));
    end
    drive(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b0);
    chk("drained_valid", {31'h0, tx_valid}, 32'h0);
    chk("status_empty_ovf", ReadData, 32'h5);
    drive(1'b0, 1'b1, MB + 32'd4, 32'h0, 1'b0);
    drive(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b0);
    chk("ovf_cleared", ReadData, 32'h1);

    // push and pop together while full
    for (int k = 10; k <= 13; k++) drive(1'b0, 1'b1, MB, 32'(k), 1'b0);
    drive(1'b0, 1'b1, MB, 32'd9, 1'b1);
    chk("full_pushpop_head", tx_data, 32'd10);
    drive(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b0);
    chk("full_pushpop_status", ReadData, 32'h2);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b1);
      chk("pushpop_drain", tx_data, drain[k]);
    end

    // error accesses
    drive(1'b0, 1'b1, MB + 32'd12, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h13, 32'h5555_5555, 1'b0);
    drive(1'b0, 1'b1, 32'h8000_0000, 32'h6666_6666, 1'b0);
    drive(1'b0, 1'b0, 32'h13, 32'h0, 1'b0);
    chk("misaligned_reads_0", ReadData, 32'h0);
    drive(1'b0, 1'b0, 32'h8000_0000, 32'h0, 1'b0);
    chk("unmapped_reads_0", ReadData, 32'h0);
    drive(1'b0, 1'b0, MB + 32'd12, 32'h0, 1'b0);
    chk("errcnt_2", ReadData, 32'd2);
    drive(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("ram_untouched", ReadData, 32'hDEAD_BEEF);

    // randomized traffic, including occasional resets
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, DW - 1)) << 2;
        1:       a = MB + 32'($urandom_range(0, 15));
        2:       a = $urandom;
        default: a = 32'($urandom_range(0, 255)) | 32'h1;
      endcase
      drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), a, $urandom,
            1'($urandom_range(0, 1)));
    end

    // reset with queued entries and a nonzero error count
    drive(1'b0, 1'b1, MB + 32'd4, 32'h0, 1'b1);
    drive(1'b0, 1'b1, MB + 32'd12, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 32'h1, 32'h0, 1'b0);
    for (int k = 21; k <= 23; k++) drive(1'b0, 1'b1, MB, 32'(k), 1'b0);
    drive(1'b0, 1'b0, MB + 32'd12, 32'h0, 1'b0);
    chk("errcnt_5", ReadData, 32'd5);
    drive(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b0);
    chk("status_3_queued", ReadData, 32'h0);
    chk("head_21", tx_data, 32'd21);
    drive(1'b1, 1'b1, MB, 32'd77, 1'b1);
    drive(1'b0, 1'b0, MB + 32'd8, 32'h0, 1'b0);
    chk("post_reset_cycle", ReadData, 32'h0);
    chk("post_reset_valid", {31'h0, tx_valid}, 32'h0);
    chk("post_reset_tx_data", tx_data, 32'h0);
    drive(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b0);
    chk("post_reset_status", ReadData, 32'h1);
    drive(1'b0, 1'b0, MB + 32'd12, 32'h0, 1'b0);
    chk("post_reset_errcnt", ReadData, 32'h0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
